// File: rtl/debounce_array.sv
// debounce_array: N-channel debouncer (2-flop sync, stability counter, clean level, rise/fall/any strobes).
// Define DEBOUNCE_HOLD_EN to build the per-channel long-press (held) detector.

module debounce_array #(
    parameter int           N           = 4,
    parameter int           CNT_W       = 15,
    parameter logic [N-1:0] INVERT_MASK = {N{1'b0}},
    parameter int           HOLD_W      = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] bouncy_in,
    output logic [N-1:0] clean_out,
    output logic [N-1:0] rise_pulse,
    output logic [N-1:0] fall_pulse,
    output logic         any_change,
    output logic [N-1:0] held
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    if (N < 1 || CNT_W < 1 || HOLD_W < 1) begin : g_bad_params
        $error("debounce_array: N, CNT_W and HOLD_W must all be >= 1");
    end

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic [N-1:0]     sync1_q, sync1_d;
    logic [N-1:0]     sync2_q, sync2_d;
    logic [N-1:0]     prev_q, prev_d;
    logic [N-1:0]     clean_q, clean_d;
    logic [N-1:0]     rise_q, rise_d;
    logic [N-1:0]     fall_q, fall_d;
    logic             any_q, any_d;
    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];

    always_comb begin
        sync1_d = bouncy_in ^ INVERT_MASK;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        clean_d = clean_q;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] == prev_q[i]) begin
                cnt_d[i] = cnt_sat_inc(cnt_q[i]);
                // Saturated counter keeps re-loading the level; pulses come only from an actual change.
                if (cnt_q[i] == CNT_MAX) begin
                    clean_d[i] = sync2_q[i];
                end
            end
        end
        rise_d = clean_d & ~clean_q;
        fall_d = ~clean_d & clean_q;
        any_d  = |(rise_d | fall_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            clean_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            any_q   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            any_q   <= any_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign clean_out  = clean_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign any_change = any_q;

`ifdef DEBOUNCE_HOLD_EN
    localparam logic [HOLD_W-1:0] HOLD_MAX = {HOLD_W{1'b1}};

    function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] v);
        return (v == HOLD_MAX) ? v : v + 1'b1;
    endfunction

    logic [HOLD_W-1:0] hold_q [N];
    logic [HOLD_W-1:0] hold_d [N];
    logic [N-1:0]      held_q, held_d;

    // held sets one edge after the counter saturates and drops on the same edge the level falls.
    always_comb begin
        held_d = '0;
        for (int i = 0; i < N; i++) begin
            hold_d[i] = clean_q[i] ? hold_sat_inc(hold_q[i]) : '0;
            held_d[i] = clean_d[i] & (held_q[i] | (hold_q[i] == HOLD_MAX));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_q <= '0;
            for (int i = 0; i < N; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            held_q <= held_d;
            for (int i = 0; i < N; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign held = held_q;
`else
    assign held = {N{1'b0}};
`endif

endmodule
